// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants for the score keeper: 7-seg ROM and "END" glyph ROM
package score_pkg;

  localparam int GLYPH_W    = 5;
  localparam int GLYPH_H    = 7;
  localparam int PITCH      = 6;
  localparam int NUM_GLYPHS = 3;

  // Index 0 sits in the low bits, so SEG_DIGIT[d] is the pattern for digit d.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Row 0 occupies the top 5 bits; within a row the MSB is the leftmost column.
  localparam logic [34:0] GLYPH_E = {5'b11111, 5'b10000, 5'b10000, 5'b11110,
                                     5'b10000, 5'b10000, 5'b11111};
  localparam logic [34:0] GLYPH_N = {5'b10001, 5'b11001, 5'b10101, 5'b10011,
                                     5'b10001, 5'b10001, 5'b10001};
  localparam logic [34:0] GLYPH_D = {5'b11110, 5'b10001, 5'b10001, 5'b10001,
                                     5'b10001, 5'b10001, 5'b11110};

  function automatic logic glyph_bit(input logic [1:0] glyph,
                                     input logic [2:0] row,
                                     input logic [2:0] col);
    logic [34:0] rows;
    logic [5:0]  idx;
    case (glyph)
      2'd0:    rows = GLYPH_E;
      2'd1:    rows = GLYPH_N;
      default: rows = GLYPH_D;
    endcase
    if (row >= 3'(GLYPH_H) || col >= 3'(GLYPH_W)) begin
      return 1'b0;
    end
    idx = 6'(34 - 5 * int'(row) - int'(col));
    return rows[idx];
  endfunction

endpackage

// File: rtl/score_counter_display_if.sv
// rtl/score_counter_display_if.sv - game-side and pixel-side signals of the score keeper
interface score_counter_display_if #(
  parameter int SCORE_W = 5
) ();
  logic               hit;
  logic               clear;
  logic [SCORE_W-1:0] max_score;
  logic [9:0]         x;
  logic [9:0]         y;
  logic [SCORE_W-1:0] score;
  logic [6:0]         seg_tens;
  logic [6:0]         seg_ones;
  logic               reached;
  logic               end_pix;

  modport master (
    output hit, clear, max_score, x, y,
    input  score, seg_tens, seg_ones, reached, end_pix
  );

  modport slave (
    input  hit, clear, max_score, x, y,
    output score, seg_tens, seg_ones, reached, end_pix
  );
endinterface

// File: rtl/endgame_text_render.sv
// rtl/endgame_text_render.sv - combinational "END" banner mask for the end-game screen
module endgame_text_render
  import score_pkg::*;
#(
  parameter int END_X0 = 276,
  parameter int END_Y0 = 220,
  parameter int SCALE  = 4
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       end_pix
);

  localparam int SHIFT = $clog2(SCALE);
  localparam int BOX_W = (NUM_GLYPHS * PITCH - 1) * SCALE;
  localparam int BOX_H = GLYPH_H * SCALE;

  logic [9:0] dx;
  logic [9:0] dy;
  logic       in_box;
  logic [4:0] cell_x;
  logic [2:0] cell_y;
  logic [1:0] glyph;
  logic [2:0] col;

  assign dx = x - 10'(END_X0);
  assign dy = y - 10'(END_Y0);

  // The lower-bound compare guards against dx/dy wrapping when left of or above the box.
  assign in_box = (x >= 10'(END_X0)) && (dx < 10'(BOX_W)) &&
                  (y >= 10'(END_Y0)) && (dy < 10'(BOX_H));

  assign cell_x = 5'(dx >> SHIFT);
  assign cell_y = 3'(dy >> SHIFT);

  always_comb begin
    glyph = 2'd0;
    col   = 3'd0;
    if (cell_x < 5'(PITCH)) begin
      glyph = 2'd0;
      col   = cell_x[2:0];
    end else if (cell_x < 5'(2 * PITCH)) begin
      glyph = 2'd1;
      col   = 3'(cell_x - 5'(PITCH));
    end else begin
      glyph = 2'd2;
      col   = 3'(cell_x - 5'(2 * PITCH));
    end
  end

  // Column 5 of each pitch is the inter-glyph gap; glyph_bit returns 0 there.
  assign end_pix = in_box && glyph_bit(glyph, cell_y, col);

endmodule

// File: rtl/score_counter_display.sv
// rtl/score_counter_display.sv - per-player score counter with 7-seg digits and END banner
module score_counter_display
  import score_pkg::*;
#(
  parameter int SCORE_W = 5,
  parameter int END_X0  = 276,
  parameter int END_Y0  = 220,
  parameter int SCALE   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  score_counter_display_if.slave  bus
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [SCORE_W-1:0] score_q;
  logic               hit_q;
  logic               rise;
  logic [3:0]         tens;
  logic [3:0]         ones;

  assign rise = bus.hit & ~hit_q;

  // Clear takes priority; a rise in the same cycle is lost but hit_q still tracks hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= bus.hit;
      if (bus.clear) begin
        score_q <= '0;
      end else if (rise && (score_q != SCORE_MAX)) begin
        score_q <= score_q + SCORE_W'(1);
      end
    end
  end

  assign tens = 4'(score_q / SCORE_W'(10));
  assign ones = 4'(score_q % SCORE_W'(10));

  assign bus.score    = score_q;
  assign bus.reached  = (score_q == bus.max_score);
  assign bus.seg_tens = SEG_DIGIT[tens];
  assign bus.seg_ones = SEG_DIGIT[ones];

  endgame_text_render #(
    .END_X0 (END_X0),
    .END_Y0 (END_Y0),
    .SCALE  (SCALE)
  ) u_text (
    .x       (bus.x),
    .y       (bus.y),
    .end_pix (bus.end_pix)
  );

endmodule

// File: tb/tb_score_counter_display.sv
// tb/tb_score_counter_display.sv - scoreboard bench for score_counter_display
module tb_score_counter_display;

  localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  typedef struct {
    bit         is_pix;
    string      name;
    logic [4:0] score;
    logic [6:0] tens;
    logic [6:0] ones;
    logic       reached;
    logic       pix;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  score_counter_display_if #(.SCORE_W(5)) bus ();

  score_counter_display #(
    .SCORE_W (5),
    .END_X0  (276),
    .END_Y0  (220),
    .SCALE   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.hit = 1'b1;
    tick();
    bus.hit = 1'b0;
    tick();
  endtask

  task automatic push_score(input string name, input int s, input logic rch);
    exp_t e;
    e.is_pix  = 1'b0;
    e.name    = name;
    e.score   = 5'(s);
    e.tens    = SEG[s / 10];
    e.ones    = SEG[s % 10];
    e.reached = rch;
    e.pix     = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_pix(input string name, input int px, input int py, input logic p);
    exp_t e;
    bus.x     = 10'(px);
    bus.y     = 10'(py);
    e.is_pix  = 1'b1;
    e.name    = name;
    e.score   = '0;
    e.tens    = '0;
    e.ones    = '0;
    e.reached = 1'b0;
    e.pix     = p;
    q.push_back(e);
    tick();
  endtask

  // Monitor: outputs are steady mid-cycle, so every pending expectation is checked on negedge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.is_pix) begin
        cmp({e.name, ".end_pix"}, int'(bus.end_pix), int'(e.pix));
      end else begin
        cmp({e.name, ".score"},    int'(bus.score),    int'(e.score));
        cmp({e.name, ".seg_tens"}, int'(bus.seg_tens), int'(e.tens));
        cmp({e.name, ".seg_ones"}, int'(bus.seg_ones), int'(e.ones));
        cmp({e.name, ".reached"},  int'(bus.reached),  int'(e.reached));
      end
    end
  end

  initial begin
    bus.hit       = 1'b0;
    bus.clear     = 1'b0;
    bus.max_score = 5'd0;
    bus.x         = 10'd0;
    bus.y         = 10'd0;
    reset         = 1'b1;
    tick();
    push_score("reset_state", 0, 1'b1);
    tick();
    reset = 1'b0;
    bus.max_score = 5'd20;

    repeat (3) pulse();
    push_score("three_pulses", 3, 1'b0);

    bus.hit = 1'b1;
    repeat (10) tick();
    bus.hit = 1'b0;
    tick();
    push_score("held_hit", 4, 1'b0);

    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.max_score = 5'd0;
    push_score("clear_max0", 0, 1'b1);
    tick();

    bus.max_score = 5'd12;
    repeat (11) pulse();
    push_score("eleven", 11, 1'b0);
    bus.hit = 1'b1;
    tick();
    push_score("twelve_reached", 12, 1'b1);
    bus.hit = 1'b0;
    tick();

    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (7) pulse();
    push_score("seven", 7, 1'b0);
    bus.clear = 1'b1;
    bus.hit   = 1'b1;
    tick();
    push_score("clear_beats_hit", 0, 1'b0);
    bus.clear = 1'b0;
    bus.hit   = 1'b0;
    tick();
    push_score("no_late_inc", 0, 1'b0);

    repeat (35) pulse();
    push_score("saturate", 31, 1'b0);
    tick();

    push_pix("pix_E_topleft", 276, 220, 1'b1);
    push_pix("pix_gap",       296, 220, 1'b0);
    push_pix("pix_N",         300, 220, 1'b1);
    push_pix("pix_D_last",    343, 247, 1'b0);
    push_pix("pix_outside",   344, 220, 1'b0);
    push_pix("pix_D_mid",     340, 224, 1'b1);

    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    repeat (5) pulse();
    push_score("pre_reset", 5, 1'b0);
    tick();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    cmp("async_reset.score", int'(bus.score), 0);
    tick();
    push_score("held_in_reset", 0, 1'b0);
    tick();
    reset = 1'b0;
    pulse();
    push_score("after_reset", 1, 1'b0);

    repeat (3) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
